// File: rtl/irst_sig_scanner.sv
// Register-file signature scanner: walks every architectural register through a
// dedicated read port, folds the contents into a MISR and publishes the signature.
module irst_sig_scanner #(
  parameter int                   DATA_WIDTH = 16,
  parameter int                   NUM_REGS   = 8,
  parameter int                   ADDR_WIDTH = 3,
  parameter int                   SIG_WIDTH  = 32,
  parameter logic [SIG_WIDTH-1:0] POLY       = 32'h04C11DB7,
  parameter logic [SIG_WIDTH-1:0] SEED       = 32'hFFFFFFFF,
  parameter int                   ROUNDS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  cmp_en,
  input  logic [SIG_WIDTH-1:0]  golden_sig,
  output logic [ADDR_WIDTH-1:0] irst_read_addr,
  input  logic [DATA_WIDTH-1:0] irst_reg_data,
  output logic                  busy,
  output logic                  irst_done,
  output logic [SIG_WIDTH-1:0]  rand_data,
  output logic                  mismatch
);

  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [RW-1:0]         LAST_ROUND = RW'(ROUNDS - 1);
  localparam logic [RW-1:0]         ROUND_ONE  = RW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FINAL = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [RW-1:0]           round;
  logic [SIG_WIDTH-1:0]    misr;
  logic [SIG_WIDTH-1:0]    misr_next;
  logic [SIG_WIDTH-1:0]    golden_q;
  logic                    cmp_en_q;
  logic                    last_reg;
  logic                    last_step;

  assign last_reg  = (addr == LAST_ADDR);
  assign last_step = last_reg && (round == LAST_ROUND);

  // Shift-left MISR with polynomial feedback, register data folded into the low bits
  assign misr_next = {misr[SIG_WIDTH-2:0], 1'b0}
                   ^ (misr[SIG_WIDTH-1] ? POLY : '0)
                   ^ SIG_WIDTH'(irst_reg_data);

  assign busy           = (state != IDLE);
  assign irst_read_addr = (state == SCAN) ? addr : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN: begin
        if (abort)          state_next = IDLE;
        else if (last_step) state_next = FINAL;
      end
      FINAL:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Abort in SCAN/FINAL freezes the datapath so rand_data and the flags keep their values
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr      <= '0;
      round     <= '0;
      misr      <= SEED;
      rand_data <= '0;
      irst_done <= 1'b0;
      mismatch  <= 1'b0;
      cmp_en_q  <= 1'b0;
      golden_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            misr      <= SEED;
            addr      <= '0;
            round     <= '0;
            cmp_en_q  <= cmp_en;
            golden_q  <= golden_sig;
            irst_done <= 1'b0;
            mismatch  <= 1'b0;
          end
        end
        SCAN: begin
          if (!abort) begin
            misr <= misr_next;
            if (last_reg) begin
              addr  <= '0;
              round <= round + ROUND_ONE;
            end else begin
              addr <= addr + ADDR_ONE;
            end
          end
        end
        FINAL: begin
          if (!abort) begin
            rand_data <= misr;
            mismatch  <= cmp_en_q && (misr != golden_q);
            irst_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_irst_sig_scanner.sv
// Scoreboard bench for irst_sig_scanner: three instances (plain, two rounds, seed
// with MSB set) share one register-file model; completions are checked by a monitor.
module tb_irst_sig_scanner;

  localparam int NDUT = 3;

  typedef struct {
    int          id;
    logic [31:0] rand_exp;
    logic        mm_exp;
    int          start_cyc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        abort;
  logic        cmp_en;
  logic [31:0] golden;
  logic        start_v  [NDUT];
  logic [2:0]  rd_addr_v[NDUT];
  logic [15:0] rdata_v  [NDUT];
  logic        busy_v   [NDUT];
  logic        done_v   [NDUT];
  logic [31:0] rand_v   [NDUT];
  logic        mm_v     [NDUT];
  logic        done_prev[NDUT];
  logic [15:0] rf[8];

  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign rdata_v[g] = rf[rd_addr_v[g]];
    irst_sig_scanner #(
      .SEED  ((g == 2) ? 32'h80000000 : 32'h00000000),
      .ROUNDS((g == 1) ? 2 : 1)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start_v[g]),
      .abort         (abort),
      .cmp_en        (cmp_en),
      .golden_sig    (golden),
      .irst_read_addr(rd_addr_v[g]),
      .irst_reg_data (rdata_v[g]),
      .busy          (busy_v[g]),
      .irst_done     (done_v[g]),
      .rand_data     (rand_v[g]),
      .mismatch      (mm_v[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Monitor: each rising irst_done must match the oldest outstanding expectation
  always @(negedge clk) begin
    for (int g = 0; g < NDUT; g++) begin
      if (done_v[g] === 1'b1 && done_prev[g] !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL unexpected_done: dut %0d raised irst_done with nothing expected", g);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("dut_id", g, mon_e.id);
          checkOutput("rand_data", rand_v[g], mon_e.rand_exp);
          checkOutput("mismatch", {31'b0, mm_v[g]}, {31'b0, mon_e.mm_exp});
          checkOutput("latency", cyc - mon_e.start_cyc, mon_e.lat);
        end
      end
      done_prev[g] = done_v[g];
    end
  end

  task automatic setRegs(input logic [15:0] r0, input logic [15:0] r6, input logic [15:0] r7);
    for (int i = 0; i < 8; i++) rf[i] = 16'h0;
    rf[0] = r0;
    rf[6] = r6;
    rf[7] = r7;
  endtask

  task automatic applyStimulus(input int id, input logic cmp, input logic [31:0] gold,
                               input logic [31:0] exp_rand, input logic exp_mm,
                               input int lat, input bit poke_busy);
    exp_t e;
    @(negedge clk);
    start_v[id] = 1'b1;
    cmp_en      = cmp;
    golden      = gold;
    @(posedge clk);
    #1;
    e.id = id; e.rand_exp = exp_rand; e.mm_exp = exp_mm; e.start_cyc = cyc; e.lat = lat;
    exp_q.push_back(e);
    start_v[id] = 1'b0;
    cmp_en      = 1'b0;
    golden      = 32'h0;
    checkOutput("busy_after_start", {31'b0, busy_v[id]}, 32'h1);
    for (int i = 0; i < 40 && done_v[id] !== 1'b1; i++) begin
      start_v[id] = (poke_busy && i == 3);
      @(negedge clk);
    end
    start_v[id] = 1'b0;
    if (done_v[id] !== 1'b1) checkOutput("done_timeout", {31'b0, done_v[id]}, 32'h1);
  endtask

  task automatic checkReset(input int id);
    checkOutput("rst_busy", {31'b0, busy_v[id]}, 32'h0);
    checkOutput("rst_done", {31'b0, done_v[id]}, 32'h0);
    checkOutput("rst_rand_data", rand_v[id], 32'h0);
    checkOutput("rst_mismatch", {31'b0, mm_v[id]}, 32'h0);
    checkOutput("rst_read_addr", {29'b0, rd_addr_v[id]}, 32'h0);
  endtask

  initial begin
    rst    = 1'b0;
    abort  = 1'b0;
    cmp_en = 1'b0;
    golden = 32'h0;
    for (int g = 0; g < NDUT; g++) begin
      start_v[g]   = 1'b0;
      done_prev[g] = 1'b0;
    end
    setRegs(16'h0, 16'h0, 16'h0);
    #12;
    checkReset(0);
    @(negedge clk);
    rst = 1'b1;

    // Single-round scans on instance 0 (SEED=0)
    applyStimulus(0, 1'b0, 32'h0, 32'h00000000, 1'b0, 9, 1'b0);
    setRegs(16'h0001, 16'h0, 16'h0);
    applyStimulus(0, 1'b0, 32'h0, 32'h00000080, 1'b0, 9, 1'b0);
    applyStimulus(0, 1'b1, 32'h00000081, 32'h00000080, 1'b1, 9, 1'b0);
    applyStimulus(0, 1'b1, 32'h00000080, 32'h00000080, 1'b0, 9, 1'b0);
    setRegs(16'h0, 16'h0, 16'hFFFF);
    applyStimulus(0, 1'b1, 32'h0000FFFF, 32'h0000FFFF, 1'b0, 9, 1'b0);
    setRegs(16'h0, 16'h8000, 16'h0);
    applyStimulus(0, 1'b1, 32'h00000000, 32'h00010000, 1'b1, 9, 1'b0);

    // Abort on the third scan edge: no publish, prior signature kept
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_busy", {31'b0, busy_v[0]}, 32'h0);
    checkOutput("abort_done", {31'b0, done_v[0]}, 32'h0);
    @(negedge clk);
    abort = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("abort_done_hold", {31'b0, done_v[0]}, 32'h0);
    checkOutput("abort_rand_hold", rand_v[0], 32'h00010000);
    applyStimulus(0, 1'b0, 32'h0, 32'h00010000, 1'b0, 9, 1'b0);

    // Two rounds, then feedback-exercising seed
    setRegs(16'h0001, 16'h0, 16'h0);
    applyStimulus(1, 1'b0, 32'h0, 32'h00008080, 1'b0, 17, 1'b0);
    setRegs(16'h0, 16'h0, 16'h0);
    applyStimulus(2, 1'b1, 32'h690CE0EE, 32'h690CE0EE, 1'b0, 9, 1'b0);

    // Asynchronous reset in the middle of a scan
    setRegs(16'h0001, 16'h0, 16'h0);
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkReset(0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(0, 1'b1, 32'h00000080, 32'h00000080, 1'b0, 9, 1'b1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    while (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      n_errors++;
      $display("[TB] FAIL missing_done: dut %0d never completed, wanted rand_data %h", mon_e.id, mon_e.rand_exp);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
